// File: rtl/future_seq.sv
// Control sequencer for the FUTURE full_cir round datapath: accepts a block,
// steps the datapath through NR rounds, captures cip and hands it downstream.
module future_seq #(
    parameter int          NR      = 10,
    parameter logic [63:0] RC_INIT = 64'h1248_2481_4812_8124
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  pt,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  ct,
    input  logic [63:0]  cip,
    output logic         X_en,
    output logic         X_rst,
    output logic         X_sh16,
    output logic         X_sr,
    output logic [63:0]  X_in,
    output logic         K0_en,
    output logic         K0_rst,
    output logic         K1_en,
    output logic         K1_rst,
    output logic         K_sh16,
    output logic         K_sh5,
    output logic [63:0]  K0_in,
    output logic [63:0]  K1_in,
    output logic         RC_en,
    output logic         RC_rst,
    output logic         RC_sh16,
    output logic         RC_sh5,
    output logic [63:0]  RC_in,
    output logic         sm,
    output logic         b0,
    output logic         b1,
    output logic         b2,
    output logic         b3
);

    localparam logic [3:0] NR_L = 4'(NR);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ROUND = 3'd2,
        S_CAPT  = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     rnd_q, rnd_d;
    logic [63:0]    pt_q, pt_d;
    logic [127:0]   key_q, key_d;
    logic [63:0]    ct_q, ct_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rnd_q   <= 4'd0;
            pt_q    <= 64'd0;
            key_q   <= 128'd0;
            ct_q    <= 64'd0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            pt_q    <= pt_d;
            key_q   <= key_d;
            ct_q    <= ct_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        pt_d    = pt_q;
        key_d   = key_q;
        ct_d    = ct_q;
        case (state_q)
            S_IDLE: begin
                rnd_d = 4'd0;
                if (in_valid) begin
                    pt_d    = pt;
                    key_d   = key;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                rnd_d   = 4'd1;
                state_d = S_ROUND;
            end
            S_ROUND: begin
                // The final round hands over to capture; rnd is cleared so it never exceeds NR.
                if (rnd_q >= NR_L) begin
                    rnd_d   = 4'd0;
                    state_d = S_CAPT;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            S_CAPT: begin
                ct_d    = cip;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: begin
                rnd_d   = 4'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        X_en      = 1'b0;
        X_rst     = 1'b0;
        K0_en     = 1'b0;
        K0_rst    = 1'b0;
        K1_en     = 1'b0;
        K1_rst    = 1'b0;
        K_sh5     = 1'b0;
        RC_en     = 1'b0;
        RC_rst    = 1'b0;
        RC_sh5    = 1'b0;
        sm        = 1'b0;
        case (state_q)
            S_IDLE: in_ready = 1'b1;
            S_LOAD: begin
                X_en   = 1'b1;
                X_rst  = 1'b1;
                K0_en  = 1'b1;
                K0_rst = 1'b1;
                K1_en  = 1'b1;
                K1_rst = 1'b1;
                RC_en  = 1'b1;
                RC_rst = 1'b1;
            end
            S_ROUND: begin
                X_en   = 1'b1;
                K0_en  = 1'b1;
                K1_en  = 1'b1;
                K_sh5  = 1'b1;
                RC_en  = 1'b1;
                RC_sh5 = 1'b1;
                sm     = (rnd_q == NR_L);
            end
            S_OUT:   out_valid = 1'b1;
            default: ;
        endcase
    end

    // Shift-by-16 and inverse controls belong to the decryption sequencer.
    assign X_sh16  = 1'b0;
    assign X_sr    = 1'b0;
    assign K_sh16  = 1'b0;
    assign RC_sh16 = 1'b0;

    assign X_in  = pt_q;
    assign K0_in = key_q[127:64];
    assign K1_in = key_q[63:0];
    assign RC_in = RC_INIT;
    assign ct    = ct_q;
    assign {b3, b2, b1, b0} = rnd_q;

endmodule

// File: tb/tb_future_seq.sv
// Self-checking bench for future_seq with a scoreboard of expected ciphertexts
// and a small datapath model that presents cip only in the capture cycle.
module tb_future_seq;

    localparam int          NR      = 10;
    localparam logic [63:0] RC_INIT = 64'h1248_2481_4812_8124;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [63:0]  pt = 64'd0;
    logic [127:0] key = 128'd0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [63:0]  ct;
    logic [63:0]  cip = 64'd0;
    logic         X_en, X_rst, X_sh16, X_sr;
    logic [63:0]  X_in;
    logic         K0_en, K0_rst, K1_en, K1_rst, K_sh16, K_sh5;
    logic [63:0]  K0_in, K1_in;
    logic         RC_en, RC_rst, RC_sh16, RC_sh5;
    logic [63:0]  RC_in;
    logic         sm, b0, b1, b2, b3;

    int checks = 0;
    int failures = 0;

    logic [63:0] exp_q[$];
    logic [63:0] cip_q[$];
    logic        prev_sm = 1'b0;

    logic [14:0] ctrl;
    logic [3:0]  bidx;
    assign ctrl = {X_en, X_rst, X_sh16, X_sr, K0_en, K0_rst, K1_en, K1_rst,
                   K_sh16, K_sh5, RC_en, RC_rst, RC_sh16, RC_sh5, sm};
    assign bidx = {b3, b2, b1, b0};

    localparam logic [14:0] CTRL_LOAD = 15'b110011110011000;

    future_seq #(.NR(NR), .RC_INIT(RC_INIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .pt(pt), .key(key),
        .out_valid(out_valid), .out_ready(out_ready), .ct(ct), .cip(cip),
        .X_en(X_en), .X_rst(X_rst), .X_sh16(X_sh16), .X_sr(X_sr), .X_in(X_in),
        .K0_en(K0_en), .K0_rst(K0_rst), .K1_en(K1_en), .K1_rst(K1_rst),
        .K_sh16(K_sh16), .K_sh5(K_sh5), .K0_in(K0_in), .K1_in(K1_in),
        .RC_en(RC_en), .RC_rst(RC_rst), .RC_sh16(RC_sh16), .RC_sh5(RC_sh5),
        .RC_in(RC_in), .sm(sm), .b0(b0), .b1(b1), .b2(b2), .b3(b3)
    );

    always #5 clk = ~clk;

    // Datapath model: the cycle after the final round (sm=1) is the capture
    // cycle, where the block's result is presented; otherwise cip is junk.
    always begin
        @(posedge clk);
        #1;
        if (prev_sm && cip_q.size() > 0) cip = cip_q.pop_front();
        else cip = {$urandom, $urandom};
        prev_sm = sm;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [14:0] round_ctrl(input int r);
        return {14'b10001010011001, (r == NR)};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (ct !== 64'd0) begin failures++; $display("FAIL reset_ct got=%h want=0", ct); end
        checks++; if (ctrl !== 15'd0 || bidx !== 4'd0) begin failures++; $display("FAIL reset_ctrl got=%b b=%h want=0", ctrl, bidx); end
        checks++; if (X_in !== 64'd0 || K0_in !== 64'd0 || K1_in !== 64'd0) begin failures++; $display("FAIL reset_data got=%h %h %h want=0", X_in, K0_in, K1_in); end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Full block with per-cycle control checks; leaves the DUT in OUT.
    task automatic test_load_rounds_capture(input logic [63:0] p, input logic [127:0] k,
                                            input logic [63:0] res);
        int lat;
        pt = p; key = k; in_valid = 1'b1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL load_idle_ready got=%b want=1", in_ready); end
        exp_q.push_back(res); cip_q.push_back(res);
        step();
        lat = 1;
        in_valid = 1'b0;
        pt = ~p; key = ~k;
        checks++; if (ctrl !== CTRL_LOAD || bidx !== 4'd0) begin failures++; $display("FAIL load_ctrl got=%b b=%h want=%b b=0", ctrl, bidx, CTRL_LOAD); end
        checks++; if (X_in !== p) begin failures++; $display("FAIL load_X_in got=%h want=%h", X_in, p); end
        checks++; if (K0_in !== k[127:64] || K1_in !== k[63:0]) begin failures++; $display("FAIL load_K_in got=%h %h want=%h %h", K0_in, K1_in, k[127:64], k[63:0]); end
        checks++; if (RC_in !== RC_INIT) begin failures++; $display("FAIL load_RC_in got=%h want=%h", RC_in, RC_INIT); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL load_in_ready got=%b want=0", in_ready); end
        for (int r = 1; r <= NR; r++) begin
            step(); lat++;
            checks++; if (ctrl !== round_ctrl(r) || bidx !== 4'(r)) begin failures++; $display("FAIL round_ctrl r=%0d got=%b b=%0d want=%b b=%0d", r, ctrl, bidx, round_ctrl(r), r); end
        end
        step(); lat++;
        checks++; if (ctrl !== 15'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL capt_frozen got=%b ov=%b want=0 ov=0", ctrl, out_valid); end
        step(); lat++;
        checks++; if (out_valid !== 1'b1 || lat != NR + 3) begin failures++; $display("FAIL capt_latency ov=%b lat=%0d want ov=1 lat=%0d", out_valid, lat, NR + 3); end
        checks++; if (ct !== res) begin failures++; $display("FAIL capt_ct got=%h want=%h", ct, res); end
    endtask

    task automatic test_backpressure();
        logic [63:0] e;
        out_ready = 1'b0;
        e = (exp_q.size() > 0) ? exp_q[0] : 64'hx;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++; if (out_valid !== 1'b1 || ct !== e || in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold i=%0d ov=%b ct=%h rdy=%b want ov=1 ct=%h rdy=0", i, out_valid, ct, in_ready, e); end
        end
        out_ready = 1'b1;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        checks++; if (ct !== e) begin failures++; $display("FAIL bp_pop got=%h want=%h", ct, e); end
        step();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_release ov=%b rdy=%b want ov=0 rdy=1", out_valid, in_ready); end
        step();
        checks++; if (out_valid !== 1'b0 || bidx !== 4'd0) begin failures++; $display("FAIL bp_idle ov=%b b=%h want ov=0 b=0", out_valid, bidx); end
    endtask

    task automatic test_mid_reset();
        pt = 64'h1111_2222_3333_4444; key = {2{64'h5555_6666_7777_8888}}; in_valid = 1'b1;
        exp_q.push_back(64'h0BAD_0BAD_0BAD_0BAD); cip_q.push_back(64'h0BAD_0BAD_0BAD_0BAD);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        checks++; if (bidx !== 4'd5) begin failures++; $display("FAIL midrst_round got=%0d want=5", bidx); end
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL midrst_hs rdy=%b ov=%b want rdy=1 ov=0", in_ready, out_valid); end
        checks++; if (ct !== 64'd0) begin failures++; $display("FAIL midrst_ct got=%h want=0", ct); end
        checks++; if (ctrl !== 15'd0 || bidx !== 4'd0 || X_in !== 64'd0) begin failures++; $display("FAIL midrst_ctrl got=%b b=%h x=%h want=0", ctrl, bidx, X_in); end
        exp_q.delete(); cip_q.delete();
        step();
        rst_n = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL midrst_after rdy=%b ov=%b want rdy=1 ov=0", in_ready, out_valid); end
    endtask

    task automatic test_busy_ignore();
        logic [63:0] pa, e;
        logic [127:0] ka;
        int n;
        pa = 64'hA5A5_0001_C3C3_0002; ka = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        pt = pa; key = ka; in_valid = 1'b1;
        exp_q.push_back(64'hCAFE_F00D_1234_5678); cip_q.push_back(64'hCAFE_F00D_1234_5678);
        step();
        pt = 64'hFFFF_0000_FFFF_0000; key = ~ka;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++; if (in_ready !== 1'b0 || X_in !== pa || K0_in !== ka[127:64]) begin failures++; $display("FAIL busy_ignore i=%0d rdy=%b x=%h k0=%h want rdy=0 x=%h k0=%h", i, in_ready, X_in, K0_in, pa, ka[127:64]); end
        end
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 50) begin step(); n++; end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL busy_timeout ov=%b want=1", out_valid); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        checks++; if (ct !== e) begin failures++; $display("FAIL busy_ct got=%h want=%h", ct, e); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();
        checks++; if (in_ready !== 1'b1 || exp_q.size() != 0) begin failures++; $display("FAIL busy_done rdy=%b pending=%0d want rdy=1 pending=0", in_ready, exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        int acc_cyc[$];
        int outs, cyc;
        logic [63:0] e;
        outs = 0; cyc = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        pt = 64'h0000_0000_0000_0001; key = {$urandom, $urandom, $urandom, $urandom};
        while (outs < 3 && cyc < 200) begin
            if (in_valid && in_ready) begin
                acc_cyc.push_back(cyc);
                exp_q.push_back(pt ^ 64'h5A5A_5A5A_0F0F_0F0F);
                cip_q.push_back(pt ^ 64'h5A5A_5A5A_0F0F_0F0F);
            end
            if (out_valid && out_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
                checks++; if (ct !== e) begin failures++; $display("FAIL b2b_ct n=%0d got=%h want=%h", outs, ct, e); end
                outs++;
            end
            step(); cyc++;
            if (in_valid && acc_cyc.size() > 0 && X_rst) pt = pt + 64'd1;
            if (acc_cyc.size() >= 3) in_valid = 1'b0;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (outs != 3) begin failures++; $display("FAIL b2b_timeout outs=%0d want=3", outs); end
        for (int i = 1; i < acc_cyc.size(); i++) begin
            checks++; if (acc_cyc[i] - acc_cyc[i-1] != NR + 4) begin failures++; $display("FAIL b2b_period i=%0d got=%0d want=%0d", i, acc_cyc[i] - acc_cyc[i-1], NR + 4); end
        end
        checks++; if (acc_cyc.size() != 3) begin failures++; $display("FAIL b2b_accepts got=%0d want=3", acc_cyc.size()); end
    endtask

    initial begin
        test_reset();
        test_load_rounds_capture(64'h8327_abcd_6783_553c,
                                 128'h2382bcde3298abcd_2382bcde3298abcd,
                                 64'hDEAD_BEEF_0123_4567);
        test_backpressure();
        test_mid_reset();
        test_busy_ignore();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout reached without completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

endmodule

// File: doc/future_seq.md
Name: future_seq

Overview:
- Control sequencer that sits directly upstream of the FUTURE round datapath `full_cir`.
- Accepts a 64-bit plaintext and a 128-bit key through a valid/ready handshake.
- Drives every `full_cir` load, enable, shift and select control for NR rounds.
- Captures the `cip` result into a holding register and offers it downstream through a valid/ready handshake. This replaces hand-driven control of the datapath.

Parameters:
NR, 10, number of cipher rounds (1..15)
RC_INIT, 64'h1248_2481_4812_8124, round-constant register initial value

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  plaintext/key offered
in_ready  out  1  sequencer idle, can accept
pt  in  64  plaintext
key  in  128  key; key[127:64] goes to K0, key[63:0] goes to K1
out_valid  out  1  ciphertext available
out_ready  in  1  downstream accepts ciphertext
ct  out  64  captured ciphertext
cip  in  64  datapath output from full_cir
X_en, X_rst, X_sh16, X_sr  out  1 each  state register controls
X_in  out  64  plaintext to datapath
K0_en, K0_rst, K1_en, K1_rst, K_sh16, K_sh5  out  1 each  key register controls
K0_in, K1_in  out  64 each  key halves to datapath
RC_en, RC_rst, RC_sh16, RC_sh5  out  1 each  round-constant register controls
RC_in  out  64  constant RC_INIT
sm  out  1  1 = final-round form (mix layer bypassed)
b0, b1, b2, b3  out  1 each  round index bits: b3..b0 = rnd[3:0]

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, rnd=0.
  - pt_q, key_q, ct = 0.
  - in_ready=1, out_valid=0.
  - All datapath controls = 0; b3..b0 = 0.
  - Reset asserted mid-operation aborts immediately to IDLE. No partial ct is ever presented.
- State machine (Moore; all datapath controls decoded from registered state/rnd):
  - IDLE: in_ready=1 and all controls are 0. On in_valid&&in_ready: latch pt_q and key_q, go to LOAD.
  - LOAD (1 cycle):
    - X_en=X_rst=1, K0_en=K0_rst=1, K1_en=K1_rst=1, RC_en=RC_rst=1.
    - X_in=pt_q, K0_in=key_q[127:64], K1_in=key_q[63:0], RC_in=RC_INIT.
    - Next state ROUND with rnd=1.
  - ROUND (rnd=1..NR, 1 cycle each):
    - X_en=1, X_rst=0, K0_en=K1_en=1 with their _rst=0, K_sh5=1, RC_en=1, RC_rst=0, RC_sh5=1.
    - sm = (rnd==NR).
    - When rnd<NR: rnd increments. When rnd==NR: go to CAPT.
  - CAPT (1 cycle): all enables are 0 (datapath frozen). ct <= cip at the end of the cycle. Next state OUT.
  - OUT: out_valid=1 and ct is held stable. On out_ready: go to IDLE with out_valid=0 in the next cycle.
- X_sh16, X_sr, K_sh16 and RC_sh16 are driven 0 in every state; they are reserved for the decryption sequencer.
- X_in, K0_in, K1_in and RC_in are driven continuously from pt_q, key_q and RC_INIT; they are qualified only by the _rst strobes.
- Latency: handshake at edge T puts LOAD in cycle T+1, rounds in T+2..T+NR+1, CAPT in T+NR+2, and out_valid=1 from T+NR+3. For NR=10, out_valid rises 13 cycles after acceptance.
- in_ready=0 in every state except IDLE. in_valid while busy is ignored, and pt/key changes while busy have no effect.
- out_ready while out_valid=0 is ignored. out_valid and ct stay stable indefinitely under backpressure.
- Minimum period between accepted blocks is NR+4 cycles, with no overlap.
- rnd never exceeds NR. After completion it returns to 0 in IDLE, so b3..b0 = 0 while idle.

Test Plan:
- Reset → check in_ready=1, out_valid=0, ct=0 and all controls 0. Assert rst_n=0 again mid-ROUND (rnd=5) → same values immediately, with no clock edge needed.
- Load sequence: pt=64'h8327_abcd_6783_553c, key=128'h2382bcde3298abcd_2382bcde3298abcd, in_valid for 1 cycle → in the next cycle all _en/_rst = 1, X_in=pt, K0_in=K1_in=64'h2382_bcde_3298_abcd, RC_in=RC_INIT.
- Round sequencing → 10 cycles with K_sh5=RC_sh5=X_en=1; b3..b0 counts 1..10; sm=1 only in round 10; all *_sh16 = 0 throughout.
- Capture → a bench datapath model drives cip=64'hDEAD_BEEF_0123_4567 in the CAPT cycle → ct equals that value and out_valid=1 exactly 13 cycles after acceptance.
- Backpressure: hold out_ready=0 for 20 cycles → out_valid and ct stay stable. Pulse out_ready → out_valid drops and in_ready=1 in the next cycle.
- Busy-ignore: assert in_valid with a different pt during rounds → no reload, and ct matches the first block. Back-to-back blocks are accepted NR+4 cycles apart.
